// File: rtl/pixel_frame_sequencer_if.sv
// Control/status bundle between the host and the pixel frame sequencer.
// frame_count is present only when PIXEL_SEQ_FRAME_COUNT_EN is defined.
interface pixel_frame_sequencer_if #(
    parameter int EXPOSE_W = 8
);
    logic                start;
    logic                continuous;
    logic                abort;
    logic [EXPOSE_W-1:0] expose_cycles;
    logic                busy;
    logic                frame_done;
    logic                POWER_ENABLE;
    logic                WRITE_ENABLE;
    logic                COUNTER_RESET;
    logic                ERASE;
    logic                EXPOSE;
    logic                CONVERT;
    logic                READ_RESET;
    logic                READ_CLK_IN;
`ifdef PIXEL_SEQ_FRAME_COUNT_EN
    logic [15:0]         frame_count;
`endif

    modport master (
        output start, continuous, abort, expose_cycles,
        input  busy, frame_done, POWER_ENABLE, WRITE_ENABLE, COUNTER_RESET,
               ERASE, EXPOSE, CONVERT, READ_RESET, READ_CLK_IN
`ifdef PIXEL_SEQ_FRAME_COUNT_EN
             , frame_count
`endif
    );

    modport slave (
        input  start, continuous, abort, expose_cycles,
        output busy, frame_done, POWER_ENABLE, WRITE_ENABLE, COUNTER_RESET,
               ERASE, EXPOSE, CONVERT, READ_RESET, READ_CLK_IN
`ifdef PIXEL_SEQ_FRAME_COUNT_EN
             , frame_count
`endif
    );
endinterface

// File: rtl/pixel_frame_sequencer.sv
// Erase -> expose -> convert -> read sequencer for the digital pixel array.
// Optional frame counter output enabled by PIXEL_SEQ_FRAME_COUNT_EN.
//
//  state     | meaning
//  ----------+------------------------------------------------
//  S_IDLE    | waiting for start, all outputs low
//  S_ERASE   | photodiode erase + ADC counter clear
//  S_GAP_E   | 1-cycle settle, power on
//  S_EXPOSE  | photogate integration for latched exposure
//  S_GAP_C   | 1-cycle settle before conversion
//  S_CONVERT | ramp/counter conversion, 2**BIT_DEPTH-1 cycles
//  S_GAP_R   | 1-cycle readout pointer reset
//  S_READ    | readout shifting, frame_done on last cycle
module pixel_frame_sequencer #(
    parameter int WIDTH                  = 2,
    parameter int HEIGHT                 = 2,
    parameter int OUTPUT_BUS_PIXEL_WIDTH = 2,
    parameter int BIT_DEPTH              = 10,
    parameter int ERASE_CYCLES           = 5,
    parameter int EXPOSE_W               = 8
) (
    input logic                     SYSTEM_CLK,
    input logic                     SYSTEM_RESET,
    pixel_frame_sequencer_if.slave  seq
);
    localparam int CONV_LEN = (1 << BIT_DEPTH) - 1;
    localparam int READ_LEN = (2 + WIDTH / OUTPUT_BUS_PIXEL_WIDTH) * HEIGHT + 1;
    localparam int EXP_MAX  = (1 << EXPOSE_W) - 1;
    localparam int MAX_A    = (CONV_LEN > READ_LEN) ? CONV_LEN : READ_LEN;
    localparam int MAX_B    = (EXP_MAX > ERASE_CYCLES) ? EXP_MAX : ERASE_CYCLES;
    localparam int MAX_LEN  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(ERASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_LEN - 1);
    localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ERASE, S_GAP_E, S_EXPOSE, S_GAP_C, S_CONVERT, S_GAP_R, S_READ
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [EXPOSE_W-1:0] exp_q, exp_d;
    logic [CNT_W-1:0]    expose_last;
    // {busy, frame_done, POWER_ENABLE, WRITE_ENABLE, COUNTER_RESET,
    //  ERASE, EXPOSE, CONVERT, READ_RESET, READ_CLK_IN}
    logic [9:0]          out_q, out_d;

    // Zero exposure still gets one EXPOSE cycle
    assign expose_last = (exp_q == '0) ? '0 : (CNT_W'(exp_q) - CNT_W'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        exp_d   = exp_q;
        case (state_q)
            S_IDLE: begin
                if (seq.start) begin
                    state_d = S_ERASE;
                    exp_d   = seq.expose_cycles;
                end
            end
            S_ERASE:   if (cnt_q == ERASE_LAST)  state_d = S_GAP_E;
            S_GAP_E:   state_d = S_EXPOSE;
            S_EXPOSE:  if (cnt_q == expose_last) state_d = S_GAP_C;
            S_GAP_C:   state_d = S_CONVERT;
            S_CONVERT: if (cnt_q == CONV_LAST)   state_d = S_GAP_R;
            S_GAP_R:   state_d = S_READ;
            S_READ: begin
                if (cnt_q == READ_LAST) begin
                    if (seq.continuous) begin
                        state_d = S_ERASE;
                        exp_d   = seq.expose_cycles;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default:   state_d = S_IDLE;
        endcase

        if (seq.abort) begin
            state_d = S_IDLE;
            exp_d   = exp_q;
        end

        if ((state_d != state_q) || (state_d == S_IDLE)) begin
            cnt_d = '0;
        end

        // Outputs are decoded from the next state and registered, so they
        // line up with the state register cycle for cycle.
        out_d = '0;
        case (state_d)
            S_ERASE:   out_d = 10'b10_0011_0000;
            S_GAP_E:   out_d = 10'b10_1000_0000;
            S_EXPOSE:  out_d = 10'b10_1100_1000;
            S_GAP_C:   out_d = 10'b10_1100_0000;
            S_CONVERT: out_d = 10'b10_1100_0100;
            S_GAP_R:   out_d = 10'b10_1000_0010;
            S_READ:    out_d = 10'b10_1000_0001;
            default:   out_d = '0;
        endcase
        out_d[8] = (state_d == S_READ) && (cnt_d == READ_LAST);
    end

    always_ff @(posedge SYSTEM_CLK) begin
        if (SYSTEM_RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            exp_q   <= EXPOSE_W'(1);
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            out_q   <= out_d;
        end
    end

    assign seq.busy          = out_q[9];
    assign seq.frame_done    = out_q[8];
    assign seq.POWER_ENABLE  = out_q[7];
    assign seq.WRITE_ENABLE  = out_q[6];
    assign seq.COUNTER_RESET = out_q[5];
    assign seq.ERASE         = out_q[4];
    assign seq.EXPOSE        = out_q[3];
    assign seq.CONVERT       = out_q[2];
    assign seq.READ_RESET    = out_q[1];
    assign seq.READ_CLK_IN   = out_q[0];

`ifdef PIXEL_SEQ_FRAME_COUNT_EN
    logic [15:0] frame_count_q, frame_count_d;

    assign frame_count_d = frame_count_q + {15'd0, out_d[8]};

    always_ff @(posedge SYSTEM_CLK) begin
        if (SYSTEM_RESET) begin
            frame_count_q <= '0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign seq.frame_count = frame_count_q;
`else
    // Frame counter not built; frame_done is the only completion indication.
`endif
endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Scoreboard bench: stimulus pushes expected output segments (vector, length),
// a negedge monitor run-length encodes the DUT outputs and pops/compares.
module tb_pixel_frame_sequencer;
    localparam int W    = 2;
    localparam int H    = 2;
    localparam int OBPW = 2;
    localparam int BD   = 10;
    localparam int EC   = 5;
    localparam int EW   = 8;
    localparam int CONV = (1 << BD) - 1;
    localparam int RDL  = (2 + W / OBPW) * H + 1;

    // {busy, frame_done, PE, WE, CR, ER, EX, CV, RR, RC}
    localparam logic [9:0] V_IDLE  = 10'b0000000000;
    localparam logic [9:0] V_ERASE = 10'b1000110000;
    localparam logic [9:0] V_GAPE  = 10'b1010000000;
    localparam logic [9:0] V_EXP   = 10'b1011001000;
    localparam logic [9:0] V_GAPC  = 10'b1011000000;
    localparam logic [9:0] V_CONV  = 10'b1011000100;
    localparam logic [9:0] V_GAPR  = 10'b1010000010;
    localparam logic [9:0] V_READ  = 10'b1010000001;
    localparam logic [9:0] V_DONE  = 10'b1110000001;

    typedef struct {
        logic [9:0] v;
        int         len;
    } seg_t;

    seg_t       expq[$];
    int         errors = 0;
    int         checks = 0;
    int         model_count = 0;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mon_en = 1'b0;
    logic [9:0] cur_v = '0;
    int         cur_len = 0;

    always #5 clk = ~clk;

    pixel_frame_sequencer_if #(.EXPOSE_W(EW)) bus ();

    pixel_frame_sequencer #(
        .WIDTH(W), .HEIGHT(H), .OUTPUT_BUS_PIXEL_WIDTH(OBPW),
        .BIT_DEPTH(BD), .ERASE_CYCLES(EC), .EXPOSE_W(EW)
    ) dut (
        .SYSTEM_CLK   (clk),
        .SYSTEM_RESET (rst),
        .seq          (bus)
    );

    function automatic logic [9:0] dut_vec();
        return {bus.busy, bus.frame_done, bus.POWER_ENABLE, bus.WRITE_ENABLE,
                bus.COUNTER_RESET, bus.ERASE, bus.EXPOSE, bus.CONVERT,
                bus.READ_RESET, bus.READ_CLK_IN};
    endfunction

    task automatic push(input logic [9:0] v, input int len);
        seg_t s;
        s.v   = v;
        s.len = len;
        expq.push_back(s);
    endtask

    task automatic push_prefix(input int e);
        push(V_ERASE, EC);
        push(V_GAPE, 1);
        push(V_EXP, (e < 1) ? 1 : e);
        push(V_GAPC, 1);
    endtask

    task automatic push_frame(input int e);
        push_prefix(e);
        push(V_CONV, CONV);
        push(V_GAPR, 1);
        push(V_READ, RDL - 1);
        push(V_DONE, 1);
    endtask

    task automatic close_seg(input logic [9:0] v, input int len);
        seg_t s;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_segment: got vec=%b len=%0d, required none", v, len);
        end else begin
            s = expq.pop_front();
            if (v !== s.v) begin
                errors++;
                $display("FAIL seg_vec: got %b (len %0d), required %b", v, len, s.v);
            end
            if (s.len != 0) begin
                checks++;
                if (len != s.len) begin
                    errors++;
                    $display("FAIL seg_len vec=%b: got %0d cycles, required %0d", s.v, len, s.len);
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (cur_len == 0) begin
                    cur_v   = dut_vec();
                    cur_len = 1;
                end else if (dut_vec() === cur_v) begin
                    cur_len++;
                end else begin
                    close_seg(cur_v, cur_len);
                    cur_v   = dut_vec();
                    cur_len = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bit(input int b, input logic val, input int budget, input string what);
        int n = 0;
        logic [9:0] v;
        v = dut_vec();
        while (v[b] !== val && n < budget) begin
            tick();
            n++;
            v = dut_vec();
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: got no event in %0d cycles, required bit%0d=%b", what, budget, b, val);
        end
    endtask

    task automatic check_now(input string name, input logic [9:0] req);
        checks++;
        if (dut_vec() !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, dut_vec(), req);
        end
    endtask

    task automatic check_count();
`ifdef PIXEL_SEQ_FRAME_COUNT_EN
        checks++;
        if (bus.frame_count !== model_count[15:0]) begin
            errors++;
            $display("FAIL frame_count: got %0d, required %0d", bus.frame_count, model_count[15:0]);
        end
`endif
    endtask

    task automatic start_frame(input int e, input logic cont);
        bus.start         = 1'b1;
        bus.expose_cycles = EW'(e);
        bus.continuous    = cont;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic single_frame(input int e);
        push_frame(e);
        push(V_IDLE, 0);
        start_frame(e, 1'b0);
        wait_bit(9, 1'b0, 2000, "idle");
        model_count++;
        check_count();
        repeat ($urandom_range(1, 4)) tick();
    endtask

    // n frames back to back; the next exposure is driven during each EXPOSE
    task automatic cont_frames(input int n);
        int es[4];
        for (int i = 0; i < n; i++) es[i] = $urandom_range(0, 30);
        for (int i = 0; i < n; i++) push_frame(es[i]);
        push(V_IDLE, 0);
        start_frame(es[0], 1'b1);
        for (int i = 0; i < n; i++) begin
            wait_bit(3, 1'b1, 100, "expose");
            if (i < n - 1) bus.expose_cycles = EW'(es[i+1]);
            wait_bit(8, 1'b1, 2000, "frame_done");
            tick();
            if (i == n - 2) bus.continuous = 1'b0;
        end
        bus.continuous = 1'b0;
        wait_bit(9, 1'b0, 2000, "idle");
        model_count += n;
        check_count();
        repeat ($urandom_range(1, 4)) tick();
    endtask

    task automatic abort_in_expose(input int e);
        int len, k;
        len = (e < 1) ? 1 : e;
        k   = $urandom_range(1, len);
        push(V_ERASE, EC);
        push(V_GAPE, 1);
        push(V_EXP, k);
        push(V_IDLE, 0);
        start_frame(e, 1'b0);
        wait_bit(3, 1'b1, 100, "expose");
        repeat (k - 1) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_now("abort_expose_idle", V_IDLE);
        check_count();
        repeat ($urandom_range(1, 4)) tick();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of run by 900000, required finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e;
        bus.start         = 1'b0;
        bus.continuous    = 1'b0;
        bus.abort         = 1'b0;
        bus.expose_cycles = '0;
        repeat (3) tick();
        rst = 1'b0;
        check_now("reset_outputs", V_IDLE);
        check_count();
        push(V_IDLE, 0);
        mon_en = 1'b1;
        tick();

        // Reference frame, then zero exposure
        single_frame(3);
        single_frame(0);

        // Two continuous frames with exposure 4 then 9
        push_frame(4);
        push_frame(9);
        push(V_IDLE, 0);
        start_frame(4, 1'b1);
        wait_bit(3, 1'b1, 100, "expose");
        bus.expose_cycles = EW'(9);
        wait_bit(8, 1'b1, 2000, "frame_done");
        tick();
        bus.continuous = 1'b0;
        wait_bit(9, 1'b0, 2000, "idle");
        model_count += 2;
        check_count();
        tick();

        // Abort in CONVERT cycle 100, then a full frame
        push_prefix(7);
        push(V_CONV, 100);
        push(V_IDLE, 0);
        start_frame(7, 1'b0);
        wait_bit(2, 1'b1, 100, "convert");
        repeat (99) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_now("abort_convert_idle", V_IDLE);
        check_count();
        tick();
        single_frame(5);

        // start while busy is ignored
        push_frame(6);
        push(V_IDLE, 0);
        start_frame(6, 1'b0);
        wait_bit(3, 1'b1, 100, "expose");
        tick();
        bus.start         = 1'b1;
        bus.expose_cycles = EW'(200);
        tick();
        bus.start = 1'b0;
        wait_bit(9, 1'b0, 2000, "idle");
        model_count++;
        check_count();
        tick();

        // Reset during READ cycle 4
        push_frame(2);
        void'(expq.pop_back());
        void'(expq.pop_back());
        push(V_READ, 4);
        push(V_IDLE, 0);
        start_frame(2, 1'b0);
        wait_bit(0, 1'b1, 2000, "read");
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_now("reset_in_read", V_IDLE);
        model_count = 0;
        check_count();

        // abort has priority over start in IDLE
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check_now("start_abort_idle", V_IDLE);
        tick();
        check_now("start_abort_idle2", V_IDLE);

        // Three completed frames plus one aborted
        single_frame(1);
        abort_in_expose(12);
        single_frame(2);
        single_frame(255);
        check_count();

        // Randomized mix
        for (int i = 0; i < 6; i++) begin
            e = $urandom_range(0, 40);
            case ($urandom_range(0, 2))
                0:       single_frame(e);
                1:       cont_frames($urandom_range(2, 3));
                default: abort_in_expose(e);
            endcase
        end

        repeat (3) tick();
        mon_en = 1'b0;
        if (cur_len > 0) close_seg(cur_v, cur_len);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d segments left, required 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
